// File: rtl/tank_pkg.sv
// Shared types and constants for the tank frame controller.
package tank_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC_ONE,
        CALC_TWO,
        CHECK,
        COMMIT
    } ctrl_state_t;

    // Command bit positions inside {up, down, left, right}
    localparam int CMD_UP    = 3;
    localparam int CMD_DOWN  = 2;
    localparam int CMD_LEFT  = 1;
    localparam int CMD_RIGHT = 0;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int SPRITE   = 32;

    typedef logic [9:0] pos_t;

    // Larger minus smaller, so the distance never wraps
    function automatic pos_t abs_diff(input pos_t a, input pos_t b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/tank_frame_controller_if.sv
// Bus between the frame controller, the VGA timing source and color_mapper.
interface tank_frame_controller_if;
    import tank_pkg::*;

    logic       frame_clk;
    logic [3:0] TankOneCmd;
    logic [3:0] TankTwoCmd;
    pos_t       TankOneX;
    pos_t       TankOneY;
    pos_t       TankTwoX;
    pos_t       TankTwoY;
    logic       busy;
    logic       collide;
    logic       overrun;

    // Controller side
    modport slave (
        input  frame_clk, TankOneCmd, TankTwoCmd,
        output TankOneX, TankOneY, TankTwoX, TankTwoY, busy, collide, overrun
    );

    // Stimulus / consumer side
    modport master (
        output frame_clk, TankOneCmd, TankTwoCmd,
        input  TankOneX, TankOneY, TankTwoX, TankTwoY, busy, collide, overrun
    );

endinterface

// File: rtl/tank_step.sv
// Combinational one-frame step of a single tank on both axes.
// TANK_WRAP_EN selects a toroidal screen; otherwise positions saturate at the edges.
module tank_step
    import tank_pkg::*;
#(
    parameter int STEP  = 2,
    parameter int X_MAX = 608,
    parameter int Y_MAX = 448
) (
    input  pos_t       x,
    input  pos_t       y,
    input  logic [3:0] cmd,
    output pos_t       x_next,
    output pos_t       y_next
);

    localparam pos_t STEP_P = STEP[9:0];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            // Axis 0 is X (left/right), axis 1 is Y (up/down)
            localparam pos_t MAX     = (gi == 0) ? X_MAX[9:0] : Y_MAX[9:0];
            localparam int   DEC_BIT = (gi == 0) ? CMD_LEFT : CMD_UP;
            localparam int   INC_BIT = (gi == 0) ? CMD_RIGHT : CMD_DOWN;

            pos_t p;
            pos_t res;
            logic dec;
            logic inc;

            assign p   = (gi == 0) ? x : y;
            assign dec = cmd[DEC_BIT];
            assign inc = cmd[INC_BIT];

            // Opposing commands cancel; otherwise move one step, handling the edge
            always_comb begin
                res = p;
                if (dec && !inc) begin
                    if (p < STEP_P) begin
`ifdef TANK_WRAP_EN
                        res = MAX + 10'd1 - (STEP_P - p);
`else
                        res = '0;
`endif
                    end else begin
                        res = p - STEP_P;
                    end
                end else if (inc && !dec) begin
                    if (p > MAX - STEP_P) begin
`ifdef TANK_WRAP_EN
                        res = p + STEP_P - (MAX + 10'd1);
`else
                        res = MAX;
`endif
                    end else begin
                        res = p + STEP_P;
                    end
                end
            end
        end
    endgenerate

    assign x_next = g_axis[0].res;
    assign y_next = g_axis[1].res;

endmodule

// File: rtl/tank_frame_controller.sv
// Per-frame position sequencer for the two tank sprites. One shared step unit
// computes each tank's candidate in turn; overlapping candidates are rejected.
// Optional macro TANK_WRAP_EN (in tank_step) makes the screen toroidal.
module tank_frame_controller
    import tank_pkg::*;
#(
    parameter int STEP   = 2,
    parameter int SPRITE = 32,
    parameter int X_MAX  = 608,
    parameter int Y_MAX  = 448,
    parameter int ONE_X0 = 32,
    parameter int ONE_Y0 = 224,
    parameter int TWO_X0 = 576,
    parameter int TWO_Y0 = 224
) (
    input  logic                     Clk,
    input  logic                     Reset,
    tank_frame_controller_if.slave   bus
);

    localparam pos_t SPRITE_P = SPRITE[9:0];

    ctrl_state_t state_reg, state_next;
    logic        sync1_reg, sync2_reg, sync3_reg;
    logic        frame_tick;
    logic [3:0]  cmd_one_reg, cmd_two_reg;
    pos_t        cand_one_x_reg, cand_one_y_reg, cand_two_x_reg, cand_two_y_reg;
    pos_t        one_x_reg, one_y_reg, two_x_reg, two_y_reg;
    logic        overlap_reg;
    logic        overrun_reg;
    pos_t        step_x_in, step_y_in, step_x_out, step_y_out;
    logic [3:0]  step_cmd;

    // Two-flop synchronizer for frame_clk plus a delay flop for edge detection
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            sync3_reg <= 1'b0;
        end else begin
            sync1_reg <= bus.frame_clk;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
        end
    end

    assign frame_tick = sync2_reg & ~sync3_reg;

    // Shared step unit: tank two's operands only during CALC_TWO
    assign step_x_in = (state_reg == CALC_TWO) ? two_x_reg : one_x_reg;
    assign step_y_in = (state_reg == CALC_TWO) ? two_y_reg : one_y_reg;
    assign step_cmd  = (state_reg == CALC_TWO) ? cmd_two_reg : cmd_one_reg;

    tank_step #(
        .STEP  (STEP),
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_step (
        .x      (step_x_in),
        .y      (step_y_in),
        .cmd    (step_cmd),
        .x_next (step_x_out),
        .y_next (step_y_out)
    );

    // FSM state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Fixed five-state sequence started by a frame tick
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (frame_tick) state_next = CALC_ONE;
            CALC_ONE: state_next = CALC_TWO;
            CALC_TWO: state_next = CHECK;
            CHECK:    state_next = COMMIT;
            COMMIT:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Datapath: latch commands, capture candidates, test overlap, commit
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cmd_one_reg    <= '0;
            cmd_two_reg    <= '0;
            cand_one_x_reg <= '0;
            cand_one_y_reg <= '0;
            cand_two_x_reg <= '0;
            cand_two_y_reg <= '0;
            overlap_reg    <= 1'b0;
            one_x_reg      <= ONE_X0[9:0];
            one_y_reg      <= ONE_Y0[9:0];
            two_x_reg      <= TWO_X0[9:0];
            two_y_reg      <= TWO_Y0[9:0];
        end else begin
            case (state_reg)
                IDLE: begin
                    if (frame_tick) begin
                        cmd_one_reg <= bus.TankOneCmd;
                        cmd_two_reg <= bus.TankTwoCmd;
                    end
                end
                CALC_ONE: begin
                    cand_one_x_reg <= step_x_out;
                    cand_one_y_reg <= step_y_out;
                end
                CALC_TWO: begin
                    cand_two_x_reg <= step_x_out;
                    cand_two_y_reg <= step_y_out;
                end
                CHECK: begin
                    overlap_reg <= (abs_diff(cand_one_x_reg, cand_two_x_reg) < SPRITE_P) &&
                                   (abs_diff(cand_one_y_reg, cand_two_y_reg) < SPRITE_P);
                end
                COMMIT: begin
                    if (!overlap_reg) begin
                        one_x_reg <= cand_one_x_reg;
                        one_y_reg <= cand_one_y_reg;
                        two_x_reg <= cand_two_x_reg;
                        two_y_reg <= cand_two_y_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky flag for frame ticks that arrive while a sequence is running
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                                 overrun_reg <= 1'b0;
        else if (frame_tick && state_reg != IDLE)  overrun_reg <= 1'b1;
    end

    assign bus.TankOneX = one_x_reg;
    assign bus.TankOneY = one_y_reg;
    assign bus.TankTwoX = two_x_reg;
    assign bus.TankTwoY = two_y_reg;
    assign bus.busy     = (state_reg != IDLE);
    assign bus.collide  = (state_reg == COMMIT) && overlap_reg;
    assign bus.overrun  = overrun_reg;

endmodule

// File: tb/tb_tank_frame_controller.sv
// Scoreboard bench for tank_frame_controller: each frame pushes the model's
// expected commit; a negedge monitor pops and compares when busy falls.
module tb_tank_frame_controller;

    logic Clk = 1'b0;
    logic Reset;

    tank_frame_controller_if bus();

    tank_frame_controller dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0] x1;
        logic [9:0] y1;
        logic [9:0] x2;
        logic [9:0] y2;
        bit         col;
    } exp_t;

    exp_t sb[$];
    int   m1x, m1y, m2x, m2y;
    int   pass_count  = 0;
    int   check_count = 0;

    // Reference step of one axis
    function automatic int mstep(input int p, input bit dec, input bit inc, input int mx);
        int r;
        r = p;
        if (dec && !inc)      r = p - 2;
        else if (inc && !dec) r = p + 2;
`ifdef TANK_WRAP_EN
        if (r < 0)       r = r + mx + 1;
        else if (r > mx) r = r - (mx + 1);
`else
        if (r < 0)       r = 0;
        else if (r > mx) r = mx;
`endif
        return r;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m1x = 32; m1y = 224; m2x = 576; m2y = 224;
    endtask

    task automatic push_frame(input logic [3:0] c1, input logic [3:0] c2);
        int a1x, a1y, a2x, a2y;
        bit ov;
        exp_t e;
        a1x = mstep(m1x, c1[1], c1[0], 608);
        a1y = mstep(m1y, c1[3], c1[2], 448);
        a2x = mstep(m2x, c2[1], c2[0], 608);
        a2y = mstep(m2y, c2[3], c2[2], 448);
        ov  = (iabs(a1x - a2x) < 32) && (iabs(a1y - a2y) < 32);
        if (!ov) begin
            m1x = a1x; m1y = a1y; m2x = a2x; m2y = a2y;
        end
        e.x1 = 10'(m1x); e.y1 = 10'(m1y); e.x2 = 10'(m2x); e.y2 = 10'(m2y); e.col = ov;
        sb.push_back(e);
    endtask

    // Monitor: one transaction line per commit, checks latency, stability, collide
    bit         prev_busy = 1'b0;
    int         busy_len  = 0;
    int         col_cycles = 0;
    bit         unstable  = 1'b0;
    logic [9:0] s1x, s1y, s2x, s2y;

    always @(negedge Clk) begin
        if (Reset) begin
            prev_busy  = 1'b0;
            busy_len   = 0;
            col_cycles = 0;
            unstable   = 1'b0;
        end else begin
            if (bus.busy) begin
                if (!prev_busy) begin
                    s1x = bus.TankOneX; s1y = bus.TankOneY;
                    s2x = bus.TankTwoX; s2y = bus.TankTwoY;
                end else if (bus.TankOneX !== s1x || bus.TankOneY !== s1y ||
                             bus.TankTwoX !== s2x || bus.TankTwoY !== s2y) begin
                    unstable = 1'b1;
                end
                busy_len++;
                if (bus.collide) col_cycles++;
            end else if (bus.collide) begin
                col_cycles++;
            end
            if (prev_busy && !bus.busy) begin
                check_count++;
                if (sb.size() == 0) begin
                    $display("FAIL commit_unexpected: commit seen with empty scoreboard");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("commit one=(%0d,%0d) two=(%0d,%0d) collide_cycles=%0d busy=%0d",
                             bus.TankOneX, bus.TankOneY, bus.TankTwoX, bus.TankTwoY, col_cycles, busy_len);
                    if (bus.TankOneX !== e.x1 || bus.TankOneY !== e.y1 ||
                        bus.TankTwoX !== e.x2 || bus.TankTwoY !== e.y2)
                        $display("FAIL commit_pos: got (%0d,%0d)/(%0d,%0d) want (%0d,%0d)/(%0d,%0d)",
                                 bus.TankOneX, bus.TankOneY, bus.TankTwoX, bus.TankTwoY,
                                 e.x1, e.y1, e.x2, e.y2);
                    else pass_count++;
                    check_count++;
                    if (col_cycles != (e.col ? 1 : 0))
                        $display("FAIL commit_collide: got %0d cycles want %0d", col_cycles, e.col ? 1 : 0);
                    else pass_count++;
                end
                check_count++;
                if (busy_len != 4 || unstable)
                    $display("FAIL commit_timing: busy cycles %0d want 4, unstable=%0d", busy_len, unstable);
                else pass_count++;
                busy_len   = 0;
                col_cycles = 0;
                unstable   = 1'b0;
            end
            prev_busy = bus.busy;
        end
    end

    task automatic wait_commit();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_count++;
            $display("FAIL commit_timeout: %0d expected commits outstanding, want 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge Clk);
    endtask

    task automatic do_frame(input logic [3:0] c1, input logic [3:0] c2, input bit scramble);
        @(negedge Clk);
        bus.TankOneCmd = c1;
        bus.TankTwoCmd = c2;
        bus.frame_clk  = 1'b1;
        push_frame(c1, c2);
        repeat (4) @(negedge Clk);
        if (scramble) begin
            bus.TankOneCmd = ~c1;
            bus.TankTwoCmd = ~c2;
        end
        repeat (2) @(negedge Clk);
        bus.frame_clk = 1'b0;
        wait_commit();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.frame_clk  = 1'b0;
        bus.TankOneCmd = 4'b0000;
        bus.TankTwoCmd = 4'b0000;
        model_reset();
        repeat (3) @(negedge Clk);
        check_count++;
        if (bus.TankOneX !== 10'd32 || bus.TankOneY !== 10'd224 ||
            bus.TankTwoX !== 10'd576 || bus.TankTwoY !== 10'd224)
            $display("FAIL reset_pos: got (%0d,%0d)/(%0d,%0d) want (32,224)/(576,224)",
                     bus.TankOneX, bus.TankOneY, bus.TankTwoX, bus.TankTwoY);
        else pass_count++;
        check_count++;
        if ({bus.busy, bus.collide, bus.overrun} !== 3'b000)
            $display("FAIL reset_flags: got busy/collide/overrun=%b want 000",
                     {bus.busy, bus.collide, bus.overrun});
        else pass_count++;
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_right();
        for (int i = 0; i < 3; i++) do_frame(4'b0001, 4'b0000, 1'b0);
        check_count++;
        if (bus.TankOneX !== 10'd38 || bus.TankTwoX !== 10'd576)
            $display("FAIL right_3frames: got X1=%0d X2=%0d want 38 576", bus.TankOneX, bus.TankTwoX);
        else pass_count++;
    endtask

    task automatic test_cancel_axes();
        do_frame(4'b0000, 4'b1100, 1'b0);
        do_frame(4'b0000, 4'b0011, 1'b0);
        do_frame(4'b0000, 4'b0000, 1'b0);
        check_count++;
        if (bus.TankTwoX !== 10'd576 || bus.TankTwoY !== 10'd224)
            $display("FAIL cancel_axes: got (%0d,%0d) want (576,224)", bus.TankTwoX, bus.TankTwoY);
        else pass_count++;
    endtask

    task automatic test_cmd_change();
        do_frame(4'b0100, 4'b1000, 1'b1);
        check_count++;
        if (bus.TankOneY !== 10'(m1y) || bus.TankTwoY !== 10'(m2y))
            $display("FAIL cmd_change: got Y1=%0d Y2=%0d want %0d %0d",
                     bus.TankOneY, bus.TankTwoY, m1y, m2y);
        else pass_count++;
    endtask

    task automatic test_left_edge();
        int n;
        n = 0;
        while (m1x != 0 && n < 40) begin
            do_frame(4'b0010, 4'b0000, 1'b0);
            n++;
        end
        do_frame(4'b0010, 4'b0000, 1'b0);
        check_count++;
        if (bus.TankOneX !== 10'(m1x))
            $display("FAIL left_edge: got X1=%0d want %0d", bus.TankOneX, m1x);
        else pass_count++;
    endtask

    task automatic test_collide();
        int n;
        n = 0;
        while (m1x != 540 && n < 400) begin
            do_frame(4'b0001, 4'b0000, 1'b0);
            n++;
        end
        for (int i = 0; i < 3; i++) do_frame(4'b0001, 4'b0000, 1'b0);
        check_count++;
        if (bus.TankOneX !== 10'(m1x) || bus.collide !== 1'b0)
            $display("FAIL collide_hold: got X1=%0d collide=%b want %0d 0", bus.TankOneX, bus.collide, m1x);
        else pass_count++;
    endtask

    task automatic test_overrun();
        do_frame(4'b0010, 4'b0000, 1'b0);
        @(negedge Clk);
        bus.TankOneCmd = 4'b0010;
        bus.TankTwoCmd = 4'b0010;
        bus.frame_clk  = 1'b1;
        push_frame(4'b0010, 4'b0010);
        @(negedge Clk);
        bus.frame_clk = 1'b0;
        @(negedge Clk);
        bus.frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        bus.frame_clk = 1'b0;
        wait_commit();
        repeat (6) @(negedge Clk);
        check_count++;
        if (bus.overrun !== 1'b1 || bus.TankOneX !== 10'(m1x) || bus.TankTwoX !== 10'(m2x))
            $display("FAIL overrun: got ovr=%b X1=%0d X2=%0d want 1 %0d %0d",
                     bus.overrun, bus.TankOneX, bus.TankTwoX, m1x, m2x);
        else pass_count++;
        do_frame(4'b0000, 4'b0000, 1'b0);
        check_count++;
        if (bus.overrun !== 1'b1)
            $display("FAIL overrun_sticky: got %b want 1", bus.overrun);
        else pass_count++;
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge Clk);
        bus.TankOneCmd = 4'b0001;
        bus.TankTwoCmd = 4'b0010;
        bus.frame_clk  = 1'b1;
        n = 0;
        while (!bus.busy && n < 10) begin
            @(negedge Clk);
            n++;
        end
        check_count++;
        if (!bus.busy) $display("FAIL reset_mid_start: busy=%b want 1", bus.busy);
        else pass_count++;
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        model_reset();
        check_count++;
        if (bus.TankOneX !== 10'd32 || bus.TankOneY !== 10'd224 ||
            bus.TankTwoX !== 10'd576 || bus.TankTwoY !== 10'd224)
            $display("FAIL reset_mid_pos: got (%0d,%0d)/(%0d,%0d) want (32,224)/(576,224)",
                     bus.TankOneX, bus.TankOneY, bus.TankTwoX, bus.TankTwoY);
        else pass_count++;
        check_count++;
        if (bus.busy !== 1'b0 || bus.overrun !== 1'b0)
            $display("FAIL reset_mid_flags: got busy=%b overrun=%b want 0 0", bus.busy, bus.overrun);
        else pass_count++;
        bus.frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        do_frame(4'b0001, 4'b0000, 1'b0);
        check_count++;
        if (bus.TankOneX !== 10'd34)
            $display("FAIL reset_mid_after: got X1=%0d want 34", bus.TankOneX);
        else pass_count++;
    endtask

    initial begin
        test_reset();
        test_right();
        test_cancel_axes();
        test_cmd_change();
        test_left_edge();
        test_collide();
        test_overrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
